// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALU operation encodings, NOP field values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DATA_W  = 32;    // datapath width
    localparam int REG_AW  = 5;     // register address width
    localparam int ALUOP_W = 4;     // aluop width

    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLL  = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL  = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA  = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALUOP_SLT  = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU = 4'b1010;

    // A NOP in EX is "add $0 = 0 + 0" with every write enable low.
    localparam logic [ALUOP_W-1:0] NOP_ALUOP = ALUOP_ADD;
    localparam logic [REG_AW-1:0]  NOP_WADDR = '0;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Operand forwarding mux: picks the newest value of one source register from EX/MEM, MEM/WB or the reg file read.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Build option: ID_EX_FWD_EN defined enables forwarding; otherwise fwd_data is reg_data and the
// mem_*/wb_* inputs are ignored (the hazard unit then stalls until writeback).
// Ports: src_addr/reg_data = registered source index and data; mem_*/wb_* = forwarding sources;
//        fwd_data = resolved operand.
module fwd_sel #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] src_addr,
    input  logic [DW-1:0]  reg_data,
    input  logic           mem_regwrite,
    input  logic [RAW-1:0] mem_waddr,
    input  logic [DW-1:0]  mem_wdata,
    input  logic           wb_regwrite,
    input  logic [RAW-1:0] wb_waddr,
    input  logic [DW-1:0]  wb_wdata,
    output logic [DW-1:0]  fwd_data
);

`ifdef ID_EX_FWD_EN
    // $0 is hard-wired zero: a "write" to it in flight must never leak into an operand.
    // MEM is checked first because it carries the younger result.
    always_comb begin
        fwd_data = reg_data;
        if (src_addr != '0) begin
            if (mem_regwrite && (mem_waddr == src_addr)) begin
                fwd_data = mem_wdata;
            end else if (wb_regwrite && (wb_waddr == src_addr)) begin
                fwd_data = wb_wdata;
            end
        end
    end
`else
    assign fwd_data = reg_data;

    logic unused_fwd;
    assign unused_fwd = ^{src_addr, mem_regwrite, mem_waddr, mem_wdata,
                          wb_regwrite, wb_waddr, wb_wdata};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding; drives the ALU and EX/MEM control.
// Latency: 1 cycle ID -> EX outputs; forwarding onto alu_a/alu_b/ex_store_data is combinational.
// Backpressure: hold freezes the instruction (operand data refreshed from forwarding); bubble/flush load a NOP.
//
// Build option: ID_EX_FWD_EN enables the EX/MEM and MEM/WB forwarding muxes (see fwd_sel).
// Ports: clk/reset (sync, active high); id_* = decoded instruction; bubble/flush/hold = pipeline control;
//        mem_*/wb_* = forwarding sources; alu_* = ALU operands/op/shift; ex_* = pc, store data, EX/MEM control.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW  = DATA_W,
    parameter int RAW = REG_AW,
    parameter int OPW = ALUOP_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           id_valid,
    input  logic [DW-1:0]  id_pc,
    input  logic [RAW-1:0] id_rs_addr,
    input  logic [RAW-1:0] id_rt_addr,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_alusrc,
    input  logic [OPW-1:0] id_aluop,
    input  logic           id_sop,
    input  logic [RAW-1:0] id_shamt,
    input  logic [RAW-1:0] id_waddr,
    input  logic           id_regwrite,
    input  logic           id_memread,
    input  logic           id_memwrite,
    input  logic           bubble,
    input  logic           flush,
    input  logic           hold,
    input  logic           mem_regwrite,
    input  logic [RAW-1:0] mem_waddr,
    input  logic [DW-1:0]  mem_wdata,
    input  logic           wb_regwrite,
    input  logic [RAW-1:0] wb_waddr,
    input  logic [DW-1:0]  wb_wdata,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_pc,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    output logic [RAW-1:0] alu_s,
    output logic           alu_sop,
    output logic [DW-1:0]  ex_store_data,
    output logic [RAW-1:0] ex_waddr,
    output logic           ex_regwrite,
    output logic           ex_memread,
    output logic           ex_memwrite
);

    logic           r_valid;
    logic [DW-1:0]  r_pc;
    logic [RAW-1:0] r_rs_addr;
    logic [RAW-1:0] r_rt_addr;
    logic [DW-1:0]  r_rs_data;
    logic [DW-1:0]  r_rt_data;
    logic [DW-1:0]  r_imm;
    logic           r_alusrc;
    logic [OPW-1:0] r_aluop;
    logic           r_sop;
    logic [RAW-1:0] r_shamt;
    logic [RAW-1:0] r_waddr;
    logic           r_regwrite;
    logic           r_memread;
    logic           r_memwrite;

    logic [DW-1:0]  fwd_rs;
    logic [DW-1:0]  fwd_rt;

    // flush beats hold; hold beats bubble. An empty ID slot also loads a NOP so that
    // every EX output is zero whenever ex_valid is low.
    logic load_nop;
    assign load_nop = flush | (~hold & (bubble | ~id_valid));

    always_ff @(posedge clk) begin
        if (reset || load_nop) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
            r_aluop    <= NOP_ALUOP;
            r_sop      <= 1'b0;
            r_shamt    <= '0;
            r_waddr    <= NOP_WADDR;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (hold) begin
            // Results leaving MEM/WB while we wait would otherwise be lost: latch them now.
            r_rs_data <= fwd_rs;
            r_rt_data <= fwd_rt;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc;
            r_rs_addr  <= id_rs_addr;
            r_rt_addr  <= id_rt_addr;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_alusrc   <= id_alusrc;
            r_aluop    <= id_aluop;
            r_sop      <= id_sop;
            r_shamt    <= id_shamt;
            r_waddr    <= id_waddr;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
        end
    end

    fwd_sel #(.DW(DW), .RAW(RAW)) u_fwd_rs (
        .src_addr     (r_rs_addr),
        .reg_data     (r_rs_data),
        .mem_regwrite (mem_regwrite),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .wb_regwrite  (wb_regwrite),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .fwd_data     (fwd_rs)
    );

    fwd_sel #(.DW(DW), .RAW(RAW)) u_fwd_rt (
        .src_addr     (r_rt_addr),
        .reg_data     (r_rt_data),
        .mem_regwrite (mem_regwrite),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .wb_regwrite  (wb_regwrite),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .fwd_data     (fwd_rt)
    );

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign alu_a         = fwd_rs;
    assign alu_b         = r_alusrc ? r_imm : fwd_rt;
    assign alu_op        = r_aluop;
    assign alu_s         = r_shamt;
    assign alu_sop       = r_sop;
    assign ex_store_data = fwd_rt;
    assign ex_waddr      = r_waddr;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage: each record drives ID, pipeline control and
// forwarding sources for one clock, then checks every EX output against hand-computed values.
// Expectations for forwarded operands follow whether ID_EX_FWD_EN is defined.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_waddr;
    logic        id_alusrc, id_sop, id_regwrite, id_memread, id_memwrite;
    logic [3:0]  id_aluop;
    logic        bubble, flush, hold;
    logic        mem_regwrite, wb_regwrite;
    logic [4:0]  mem_waddr, wb_waddr;
    logic [31:0] mem_wdata, wb_wdata;
    logic        ex_valid, alu_sop, ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_op;
    logic [4:0]  alu_s, ex_waddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_sop(id_sop), .id_shamt(id_shamt),
        .id_waddr(id_waddr), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .bubble(bubble), .flush(flush), .hold(hold),
        .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_s(alu_s), .alu_sop(alu_sop), .ex_store_data(ex_store_data), .ex_waddr(ex_waddr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
    );

    // shamt/sop/memread/memwrite are derived from the pc so that their expected
    // values follow from the expected pc (NOP -> pc 0 -> all zero).
    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [31:0] rsd;
        logic [4:0]  rt;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic        alusrc;
        logic [3:0]  op;
        logic [4:0]  wa;
        logic [2:0]  ctl;   // {bubble, flush, hold}
        logic [1:0]  fen;   // {mem_regwrite, wb_regwrite}
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  wba;
        logic [31:0] wd;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
        logic [3:0]  eop;
        logic [4:0]  ewa;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [4:0] rs, input logic [31:0] rsd,
        input logic [4:0] rt, input logic [31:0] rtd, input logic [31:0] imm, input logic alusrc,
        input logic [3:0] op, input logic [4:0] wa, input logic [2:0] ctl, input logic [1:0] fen,
        input logic [4:0] ma, input logic [31:0] md, input logic [4:0] wba, input logic [31:0] wd,
        input logic ev, input logic [31:0] epc, input logic [31:0] ea, input logic [31:0] eb,
        input logic [31:0] es, input logic [3:0] eop, input logic [4:0] ewa);
        vec_t r;
        r.v = v; r.pc = pc; r.rs = rs; r.rsd = rsd; r.rt = rt; r.rtd = rtd; r.imm = imm;
        r.alusrc = alusrc; r.op = op; r.wa = wa; r.ctl = ctl; r.fen = fen;
        r.ma = ma; r.md = md; r.wba = wba; r.wd = wd;
        r.ev = ev; r.epc = epc; r.ea = ea; r.eb = eb; r.es = es; r.eop = eop; r.ewa = ewa;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.v;
        id_pc       = t.pc;
        id_rs_addr  = t.rs;
        id_rs_data  = t.rsd;
        id_rt_addr  = t.rt;
        id_rt_data  = t.rtd;
        id_imm      = t.imm;
        id_alusrc   = t.alusrc;
        id_aluop    = t.op;
        id_waddr    = t.wa;
        id_shamt    = t.pc[6:2];
        id_sop      = t.pc[3];
        id_memread  = t.pc[4];
        id_memwrite = t.pc[5];
        id_regwrite = 1'b1;
        {bubble, flush, hold} = t.ctl;
        {mem_regwrite, wb_regwrite} = t.fen;
        mem_waddr   = t.ma;
        mem_wdata   = t.md;
        wb_waddr    = t.wba;
        wb_wdata    = t.wd;
    endtask

    task automatic check_all(input int idx, input vec_t t);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, ".ex_valid"},      {31'd0, ex_valid},    {31'd0, t.ev});
        chk({p, ".ex_pc"},         ex_pc,                t.epc);
        chk({p, ".alu_a"},         alu_a,                t.ea);
        chk({p, ".alu_b"},         alu_b,                t.eb);
        chk({p, ".store_data"},    ex_store_data,        t.es);
        chk({p, ".alu_op"},        {28'd0, alu_op},      {28'd0, t.eop});
        chk({p, ".alu_s"},         {27'd0, alu_s},       {27'd0, t.epc[6:2]});
        chk({p, ".alu_sop"},       {31'd0, alu_sop},     {31'd0, t.epc[3]});
        chk({p, ".ex_waddr"},      {27'd0, ex_waddr},    {27'd0, t.ewa});
        chk({p, ".ex_regwrite"},   {31'd0, ex_regwrite}, {31'd0, t.ev});
        chk({p, ".ex_memread"},    {31'd0, ex_memread},  {31'd0, t.epc[4]});
        chk({p, ".ex_memwrite"},   {31'd0, ex_memwrite}, {31'd0, t.epc[5]});
    endtask

    vec_t vecs[18];

    initial begin
        // 0: addu $8(5),$9(7)
        vecs[0]  = mk(1, 32'h100, 8, 5, 9, 7, 0, 0, OP_ADD, 9, 3'b000, 2'b00, 0, 0, 0, 0,
                      1, 32'h100, 5, 7, 7, OP_ADD, 9);
        // 1: load rs=$8(1); MEM and WB both target $8 -> MEM wins
        vecs[1]  = mk(1, 32'h104, 8, 1, 9, 2, 0, 0, OP_ADD, 10, 3'b000, 2'b11, 8, 32'h11, 8, 32'h22,
                      1, 32'h104, FWD ? 32'h11 : 32'h1, 2, 2, OP_ADD, 10);
        // 2: hold, MEM match dropped, WB still forwards 0x22 (ID contents are junk)
        vecs[2]  = mk(1, 32'h1F0, 3, 32'hDEAD, 4, 32'hBEEF, 1, 1, OP_SUB, 17, 3'b001, 2'b01, 0, 0, 8, 32'h22,
                      1, 32'h104, FWD ? 32'h22 : 32'h1, 2, 2, OP_ADD, 10);
        // 3: hold with forwarding source gone: refreshed value retained
        vecs[3]  = mk(1, 32'h1F0, 3, 32'hDEAD, 4, 32'hBEEF, 1, 1, OP_SUB, 17, 3'b001, 2'b00, 0, 0, 0, 0,
                      1, 32'h104, FWD ? 32'h22 : 32'h1, 2, 2, OP_ADD, 10);
        // 4: rs=rt=$0 with MEM/WB claiming writes to $0: never forwarded
        vecs[4]  = mk(1, 32'h10C, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 3'b000, 2'b11, 0, 32'hFFFF, 0, 32'h1234,
                      1, 32'h10C, 0, 0, 0, OP_ADD, 0);
        // 5: sub $3(A),$4(B); WB forwards 0x33 to rt
        vecs[5]  = mk(1, 32'h110, 3, 32'hA, 4, 32'hB, 0, 0, OP_SUB, 12, 3'b000, 2'b01, 0, 0, 4, 32'h33,
                      1, 32'h110, 32'hA, FWD ? 32'h33 : 32'hB, FWD ? 32'h33 : 32'hB, OP_SUB, 12);
        // 6-7: hold two cycles, WB retires after the first
        vecs[6]  = mk(1, 32'h1F4, 1, 1, 1, 1, 0, 0, OP_NOR, 1, 3'b001, 2'b01, 0, 0, 4, 32'h33,
                      1, 32'h110, 32'hA, FWD ? 32'h33 : 32'hB, FWD ? 32'h33 : 32'hB, OP_SUB, 12);
        vecs[7]  = mk(1, 32'h1F4, 1, 1, 1, 1, 0, 0, OP_NOR, 1, 3'b001, 2'b00, 0, 0, 0, 0,
                      1, 32'h110, 32'hA, FWD ? 32'h33 : 32'hB, FWD ? 32'h33 : 32'hB, OP_SUB, 12);
        // 8: ori: b = imm, store data still the (forwarded) rt
        vecs[8]  = mk(1, 32'h114, 5, 32'h100, 6, 32'h77, 32'hFF, 1, OP_OR, 6, 3'b000, 2'b10, 6, 32'h55, 0, 0,
                      1, 32'h114, 32'h100, 32'hFF, FWD ? 32'h55 : 32'h77, OP_OR, 6);
        // 9: bubble -> NOP
        vecs[9]  = mk(1, 32'h118, 1, 3, 2, 4, 0, 0, OP_AND, 3, 3'b100, 2'b00, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, OP_ADD, 0);
        // 10: and $1(3),$2(4)
        vecs[10] = mk(1, 32'h118, 1, 3, 2, 4, 0, 0, OP_AND, 3, 3'b000, 2'b00, 0, 0, 0, 0,
                      1, 32'h118, 3, 4, 4, OP_AND, 3);
        // 11: flush with hold -> NOP
        vecs[11] = mk(1, 32'h11C, 7, 9, 10, 32'hC, 0, 0, OP_XOR, 11, 3'b011, 2'b00, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, OP_ADD, 0);
        // 12: xor $7(9),$10(C)
        vecs[12] = mk(1, 32'h11C, 7, 9, 10, 32'hC, 0, 0, OP_XOR, 11, 3'b000, 2'b00, 0, 0, 0, 0,
                      1, 32'h11C, 9, 32'hC, 32'hC, OP_XOR, 11);
        // 13: bubble with hold -> hold wins, instruction kept
        vecs[13] = mk(1, 32'h120, 1, 1, 1, 1, 0, 0, OP_NOR, 1, 3'b101, 2'b00, 0, 0, 0, 0,
                      1, 32'h11C, 9, 32'hC, 32'hC, OP_XOR, 11);
        // 14: flush alone -> NOP
        vecs[14] = mk(1, 32'h120, 1, 1, 1, 1, 0, 0, OP_NOR, 1, 3'b010, 2'b00, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, OP_ADD, 0);
        // 15: empty ID slot -> EX empty, outputs zero
        vecs[15] = mk(0, 32'h13C, 2, 5, 3, 6, 7, 1, OP_SUB, 4, 3'b000, 2'b00, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, OP_ADD, 0);
        // 16: slt $2,$2 with MEM and WB both on $2 -> MEM value on both operands
        vecs[16] = mk(1, 32'h124, 2, 1, 2, 1, 0, 0, OP_SLT, 2, 3'b000, 2'b11, 2, 32'hAA, 2, 32'hBB,
                      1, 32'h124, FWD ? 32'hAA : 32'h1, FWD ? 32'hAA : 32'h1, FWD ? 32'hAA : 32'h1, OP_SLT, 2);
        // 17: load with only WB matching rt, MEM on another register
        vecs[17] = mk(1, 32'h128, 9, 32'h40, 12, 32'h50, 0, 0, OP_ADD, 13, 3'b000, 2'b11, 9, 32'h66, 12, 32'h99,
                      1, 32'h128, FWD ? 32'h66 : 32'h40, FWD ? 32'h99 : 32'h50, FWD ? 32'h99 : 32'h50, OP_ADD, 13);

        // Reset for one cycle with a real instruction presented in ID.
        drive(vecs[0]);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset.ex_valid",    {31'd0, ex_valid},    32'd0);
        chk("reset.alu_a",       alu_a,                32'd0);
        chk("reset.alu_b",       alu_b,                32'd0);
        chk("reset.ex_regwrite", {31'd0, ex_regwrite}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check_all(i, vecs[i]);
        end

        // Reset mid-stream overrides a load.
        drive(vecs[10]);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset2.ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset2.ex_pc",    ex_pc,             32'd0);
        chk("reset2.alu_op",   {28'd0, alu_op},   32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
